// File: rtl/ipv4_header_serializer.sv
// Latches one IPv4 header plus its precomputed checksum and streams it as five
// big-endian 32-bit beats. Define IPV4_HDR_STATS_EN to add the HDR_COUNT port.
module ipv4_header_serializer (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HDR_VALID,
   output logic        HDR_READY,
   input  logic [7:0]  VERSION,
   input  logic [7:0]  SERVICE_TYPE,
   input  logic [15:0] LENGTH,
   input  logic [15:0] IDENTIFICATION,
   input  logic [15:0] FLAGS_AND_FRAGMENT,
   input  logic [7:0]  TTL,
   input  logic [7:0]  PROTOCOL,
   input  logic [31:0] SRC_IP_ADDRESS,
   input  logic [31:0] DST_IP_ADDRESS,
   input  logic [15:0] CHECKSUM,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] OUT_DATA,
   output logic        OUT_LAST
`ifdef IPV4_HDR_STATS_EN
   ,
   output logic [31:0] HDR_COUNT
`endif
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   typedef struct packed {
      logic [7:0]  version;
      logic [7:0]  service_type;
      logic [15:0] length;
      logic [15:0] identification;
      logic [15:0] flags_and_fragment;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [15:0] checksum;
      logic [31:0] src_ip_address;
      logic [31:0] dst_ip_address;
   } hdr_t;

   localparam logic [2:0] LAST_BEAT = 3'd4;

   state_t      state_q, state_d;
   logic [2:0]  beat_q, beat_d;
   hdr_t        hdr_q, hdr_d;
   hdr_t        hdr_in;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_last_q, out_last_d;
   logic        hdr_accept;
   logic        beat_accept;

   // Word layout on the wire; first transmitted byte lands in [31:24].
   function automatic logic [31:0] beat_word(input hdr_t h, input logic [2:0] b);
      case (b)
         3'd0:    beat_word = {h.version, h.service_type, h.length};
         3'd1:    beat_word = {h.identification, h.flags_and_fragment};
         3'd2:    beat_word = {h.ttl, h.protocol, h.checksum};
         3'd3:    beat_word = h.src_ip_address;
         3'd4:    beat_word = h.dst_ip_address;
         default: beat_word = '0;
      endcase
   endfunction

   assign hdr_in = {VERSION, SERVICE_TYPE, LENGTH, IDENTIFICATION, FLAGS_AND_FRAGMENT,
                    TTL, PROTOCOL, CHECKSUM, SRC_IP_ADDRESS, DST_IP_ADDRESS};

   // Ready in the last-beat window lets the next header follow without a bubble.
   assign HDR_READY   = !RST && ((state_q == IDLE) ||
                                 (state_q == SEND && beat_q == LAST_BEAT && OUT_READY));
   assign hdr_accept  = HDR_VALID && HDR_READY;
   assign beat_accept = out_valid_q && OUT_READY;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves
      // one unassigned and no latch is inferred.
      state_d     = state_q;
      beat_d      = beat_q;
      hdr_d       = hdr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (state_q == SEND && beat_accept) begin
         if (beat_q == LAST_BEAT) begin
            state_d     = IDLE;
            beat_d      = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
         end else begin
            beat_d      = beat_q + 3'd1;
            out_data_d  = beat_word(hdr_q, beat_q + 3'd1);
            out_last_d  = ((beat_q + 3'd1) == LAST_BEAT);
         end
      end

      // A new header overrides the retirement of the previous one.
      if (hdr_accept) begin
         state_d     = SEND;
         beat_d      = '0;
         hdr_d       = hdr_in;
         out_valid_d = 1'b1;
         out_data_d  = beat_word(hdr_in, 3'd0);
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (RST) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         // NOTE: the holding registers are reset too; they are plain flops, not
         // a memory array, and a defined value after reset is required.
         hdr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         hdr_q       <= hdr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_LAST  = out_last_q;

`ifdef IPV4_HDR_STATS_EN
   logic [31:0] hdr_count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hdr_count_q <= '0;
      end else if (beat_accept && beat_q == LAST_BEAT) begin
         hdr_count_q <= hdr_count_q + 32'd1;
      end
   end

   assign HDR_COUNT = hdr_count_q;
`endif

endmodule

// File: tb/tb_ipv4_header_serializer.sv
// Self-checking bench for ipv4_header_serializer: table vectors, corner-case
// sequences and randomized traffic against a queue-based beat model.
module tb_ipv4_header_serializer;

   typedef struct packed {
      logic [7:0]  version;
      logic [7:0]  service_type;
      logic [15:0] length;
      logic [15:0] identification;
      logic [15:0] flags_and_fragment;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [15:0] checksum;
      logic [31:0] src;
      logic [31:0] dst;
   } hdr_t;

   typedef struct packed {
      hdr_t             hdr;
      logic [4:0][31:0] words;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        HDR_VALID = 1'b0;
   logic        HDR_READY;
   logic [7:0]  VERSION = '0;
   logic [7:0]  SERVICE_TYPE = '0;
   logic [15:0] LENGTH = '0;
   logic [15:0] IDENTIFICATION = '0;
   logic [15:0] FLAGS_AND_FRAGMENT = '0;
   logic [7:0]  TTL = '0;
   logic [7:0]  PROTOCOL = '0;
   logic [31:0] SRC_IP_ADDRESS = '0;
   logic [31:0] DST_IP_ADDRESS = '0;
   logic [15:0] CHECKSUM = '0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b1;
   logic [31:0] OUT_DATA;
   logic        OUT_LAST;
`ifdef IPV4_HDR_STATS_EN
   logic [31:0] HDR_COUNT;
   logic [31:0] model_count = '0;
`endif

   int errors = 0;
   int checks = 0;

   hdr_t        cur;
   vec_t        vecs[3];
   logic [32:0] exp_q[$];   // {last, data} beats still owed by the DUT
   logic [31:0] seen[$];    // beats the DUT handed over, in order

   always #5 CLK = ~CLK;

   ipv4_header_serializer dut (
      .CLK                (CLK),
      .RST                (RST),
      .HDR_VALID          (HDR_VALID),
      .HDR_READY          (HDR_READY),
      .VERSION            (VERSION),
      .SERVICE_TYPE       (SERVICE_TYPE),
      .LENGTH             (LENGTH),
      .IDENTIFICATION     (IDENTIFICATION),
      .FLAGS_AND_FRAGMENT (FLAGS_AND_FRAGMENT),
      .TTL                (TTL),
      .PROTOCOL           (PROTOCOL),
      .SRC_IP_ADDRESS     (SRC_IP_ADDRESS),
      .DST_IP_ADDRESS     (DST_IP_ADDRESS),
      .CHECKSUM           (CHECKSUM),
      .OUT_VALID          (OUT_VALID),
      .OUT_READY          (OUT_READY),
      .OUT_DATA           (OUT_DATA),
      .OUT_LAST           (OUT_LAST)
`ifdef IPV4_HDR_STATS_EN
      ,
      .HDR_COUNT          (HDR_COUNT)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic hdr_t mk(input logic [7:0] v, input logic [7:0] tos,
                               input logic [15:0] len, input logic [15:0] id,
                               input logic [15:0] ff, input logic [7:0] ttl,
                               input logic [7:0] proto, input logic [15:0] csum,
                               input logic [31:0] src, input logic [31:0] dst);
      hdr_t h;
      h.version = v;  h.service_type = tos; h.length = len; h.identification = id;
      h.flags_and_fragment = ff; h.ttl = ttl; h.protocol = proto; h.checksum = csum;
      h.src = src;    h.dst = dst;
      return h;
   endfunction

   function automatic hdr_t rand_hdr();
      return mk($urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom);
   endfunction

   // Expected stream for one header: five words in wire order, big-endian.
   task automatic push_header(input hdr_t h);
      exp_q.push_back({1'b0, h.version, h.service_type, h.length});
      exp_q.push_back({1'b0, h.identification, h.flags_and_fragment});
      exp_q.push_back({1'b0, h.ttl, h.protocol, h.checksum});
      exp_q.push_back({1'b0, h.src});
      exp_q.push_back({1'b1, h.dst});
   endtask

   // One clock: drive at the falling edge, check, then advance the model to
   // what the next rising edge must produce.
   task automatic cycle(input logic hv, input logic ordy, input logic rst);
      logic model_ready;
      logic [32:0] head;
      @(negedge CLK);
      HDR_VALID = hv;  OUT_READY = ordy;  RST = rst;
      VERSION = cur.version;  SERVICE_TYPE = cur.service_type;  LENGTH = cur.length;
      IDENTIFICATION = cur.identification;  FLAGS_AND_FRAGMENT = cur.flags_and_fragment;
      TTL = cur.ttl;  PROTOCOL = cur.protocol;  CHECKSUM = cur.checksum;
      SRC_IP_ADDRESS = cur.src;  DST_IP_ADDRESS = cur.dst;
      #1;
      model_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
      check("hdr_ready", {31'd0, HDR_READY}, {31'd0, model_ready});
      check("out_valid", {31'd0, OUT_VALID}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check("out_data", OUT_DATA, head[31:0]);
         check("out_last", {31'd0, OUT_LAST}, {31'd0, head[32]});
      end
`ifdef IPV4_HDR_STATS_EN
      check("hdr_count", HDR_COUNT, model_count);
`endif
      if (OUT_VALID === 1'b1 && ordy) seen.push_back(OUT_DATA);
      if (rst) begin
         exp_q.delete();
`ifdef IPV4_HDR_STATS_EN
         model_count = '0;
`endif
      end else begin
         if (exp_q.size() != 0 && ordy) begin
            head = exp_q.pop_front();
`ifdef IPV4_HDR_STATS_EN
            if (head[32]) model_count = model_count + 32'd1;
`endif
         end
         if (hv && model_ready) push_header(cur);
      end
   endtask

   task automatic compare_seen(input string tag, input vec_t v, input int offset);
      for (int i = 0; i < 5; i++) begin
         if (offset + i < seen.size())
            check($sformatf("%s_beat%0d", tag, i), seen[offset + i], v.words[i]);
         else
            check($sformatf("%s_beat%0d_missing", tag, i), 32'hDEAD_BEEF, v.words[i]);
      end
   endtask

   initial begin
      vecs[0].hdr = mk(8'h45, 8'h00, 16'h002e, 16'h0000, 16'h0000, 8'h80, 8'h00,
                       16'h22cc, 32'h020b0101, 32'h010b0101);
      vecs[0].words = {32'h010b0101, 32'h020b0101, 32'h800022cc, 32'h00000000, 32'h4500002e};
      vecs[1].hdr = mk(8'h45, 8'h00, 16'h002e, 16'h0000, 16'h0000, 8'h80, 8'h00,
                       16'h1234, 32'h020b0101, 32'h010b0101);
      vecs[1].words = {32'h010b0101, 32'h020b0101, 32'h80001234, 32'h00000000, 32'h4500002e};
      vecs[2].hdr = mk(8'h45, 8'hb8, 16'h0054, 16'habcd, 16'h4000, 8'h40, 8'h01,
                       16'hbeef, 32'hc0a80001, 32'h08080808);
      vecs[2].words = {32'h08080808, 32'hc0a80001, 32'h4001beef, 32'habcd4000, 32'h45b80054};
      cur = vecs[0].hdr;

      // Reset state
      repeat (2) @(posedge CLK);
      cycle(1'b0, 1'b1, 1'b1);
      check("reset_out_data", OUT_DATA, 32'h0);
      check("reset_out_last", {31'd0, OUT_LAST}, 32'h0);

      // Table vectors, fields scrambled right after the handshake
      for (int v = 0; v < 3; v++) begin
         seen.delete();
         cur = vecs[v].hdr;
         cycle(1'b1, 1'b1, 1'b0);
         cur = rand_hdr();
         repeat (6) cycle(1'b0, 1'b1, 1'b0);
         check($sformatf("vec%0d_count", v), seen.size(), 32'd5);
         compare_seen($sformatf("vec%0d", v), vecs[v], 0);
      end

      // Backpressure on beat 2 for three cycles
      seen.delete();
      cur = vecs[0].hdr;
      cycle(1'b1, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      check("bp_count", seen.size(), 32'd5);
      compare_seen("bp", vecs[0], 0);

      // Back-to-back headers with HDR_VALID held high
      seen.delete();
      cur = vecs[0].hdr;
      cycle(1'b1, 1'b1, 1'b0);
      cur = vecs[1].hdr;
      repeat (5) cycle(1'b1, 1'b1, 1'b0);
      cur = rand_hdr();
      repeat (6) cycle(1'b0, 1'b1, 1'b0);
      check("b2b_count", seen.size(), 32'd10);
      compare_seen("b2b_first", vecs[0], 0);
      compare_seen("b2b_second", vecs[1], 5);

      // Reset while beat 2 is on the bus, then a clean header
      cur = vecs[2].hdr;
      cycle(1'b1, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      seen.delete();
      cur = vecs[0].hdr;
      cycle(1'b1, 1'b1, 1'b0);
      repeat (6) cycle(1'b0, 1'b1, 1'b0);
      check("post_reset_count", seen.size(), 32'd5);
      compare_seen("post_reset", vecs[0], 0);

`ifdef IPV4_HDR_STATS_EN
      // Header counter: three headers after reset, then wrap
      cycle(1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 3; n++) begin
         cur = rand_hdr();
         cycle(1'b1, 1'b1, 1'b0);
         repeat (5) cycle(1'b0, 1'b1, 1'b0);
      end
      check("stats_three", HDR_COUNT, 32'd3);
      @(negedge CLK);
      force dut.hdr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.hdr_count_q;
      model_count = 32'hFFFF_FFFF;
      cur = rand_hdr();
      cycle(1'b1, 1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      check("stats_wrap", HDR_COUNT, 32'd0);
`endif

      // Randomized traffic, backpressure and occasional resets
      for (int i = 0; i < 3000; i++) begin
         cur = rand_hdr();
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
               $urandom_range(0, 199) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
